ram_handshake_responder: RTL

Byte-addressable, big-endian data memory that serves as the responder side of the datapath's MFA/MFC memory handshake. It accepts one request per MFA assertion, inserts a programmable number of wait states, then performs the read or write and raises MFC until the initiator drops MFA. It replaces the ad-hoc RAM model behind the control unit, so memory latency can be varied without changing the microprogram.

---
 rtl/ram_handshake_responder.sv | 191 +++++++++++++++++++
 1 files changed

// File: rtl/ram_handshake_responder.sv
// ram_handshake_responder
//
// Byte-addressable, big-endian data memory acting as the responder side of
// the MFA/MFC memory handshake. One request is accepted per MFA assertion,
// WAIT_CYCLES wait states are inserted, then the read or write is performed
// and MFC is held high until the initiator drops MFA.
//
// Parameters:
//   ADDR_W      - address width; depth is 2**ADDR_W bytes
//   WAIT_CYCLES - wait states before the access (0..15)
//
// Ports:
//   CLK      in   system clock, rising-edge
//   Reset    in   asynchronous active-high reset
//   MFA      in   memory function activate (request), level-held
//   RW       in   1 = write, 0 = read
//   Type     in   00 byte, 01 halfword, 10 word, 11 reserved (as word)
//   Address  in   byte address of the most-significant byte
//   DataIn   in   write data, right-justified
//   DataOut  out  read data, zero-extended and right-justified
//   MFC      out  memory function complete
//   Fault    out  misaligned-access flag
//
// Optional feature: define RAM_ALIGN_CHECK_EN to flag misaligned halfword and
// word accesses (no write, DataOut = 0, Fault alongside MFC). Without it every
// access proceeds with modulo address wrap and Fault is constant 0.
//
// The storage array `mem` is not cleared by reset and may be preloaded
// hierarchically for test.

module ram_handshake_responder #(
    parameter int ADDR_W      = 8,
    parameter int WAIT_CYCLES = 2
) (
    input  logic              CLK,
    input  logic              Reset,
    input  logic              MFA,
    input  logic              RW,
    input  logic [1:0]        Type,
    input  logic [ADDR_W-1:0] Address,
    input  logic [31:0]       DataIn,
    output logic [31:0]       DataOut,
    output logic              MFC,
    output logic              Fault
);

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        ACCESS,
        DONE
    } state_t;

    state_t state;

    logic [7:0]        mem [0:(2**ADDR_W)-1];

    logic [3:0]        cnt;
    logic [ADDR_W-1:0] lat_addr;
    logic              lat_rw;
    logic [1:0]        lat_type;
    logic [31:0]       lat_data;

    // Byte addresses of the following bytes; wrap modulo the memory depth.
    logic [ADDR_W-1:0] a1, a2, a3;
    logic [31:0]       rd_data;
    logic              misalign;
    logic              mem_we;

    always_comb begin
        a1 = lat_addr + ADDR_W'(1);
        a2 = lat_addr + ADDR_W'(2);
        a3 = lat_addr + ADDR_W'(3);
    end

    always_comb begin
        rd_data = '0;
        case (lat_type)
            2'b00:   rd_data = {24'h0, mem[lat_addr]};
            2'b01:   rd_data = {16'h0, mem[lat_addr], mem[a1]};
            default: rd_data = {mem[lat_addr], mem[a1], mem[a2], mem[a3]};
        endcase
    end

`ifdef RAM_ALIGN_CHECK_EN
    always_comb begin
        misalign = 1'b0;
        case (lat_type)
            2'b00:   misalign = 1'b0;
            2'b01:   misalign = lat_addr[0];
            default: misalign = |lat_addr[1:0];
        endcase
    end
`else
    assign misalign = 1'b0;
`endif

    assign mem_we = (state == ACCESS) && lat_rw && !misalign;

    // Handshake FSM. The request is captured in IDLE so later changes on the
    // request inputs cannot affect the access in progress.
    always_ff @(posedge CLK or posedge Reset) begin
        if (Reset) begin
            state    <= IDLE;
            cnt      <= '0;
            MFC      <= 1'b0;
            DataOut  <= '0;
            lat_addr <= '0;
            lat_rw   <= 1'b0;
            lat_type <= '0;
            lat_data <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (MFA) begin
                        lat_addr <= Address;
                        lat_rw   <= RW;
                        lat_type <= Type;
                        lat_data <= DataIn;
                        cnt      <= 4'(WAIT_CYCLES);
                        state    <= (WAIT_CYCLES > 0) ? WAIT : ACCESS;
                    end
                end
                WAIT: begin
                    // Abort has priority: an early MFA drop discards the request.
                    if (!MFA) begin
                        state <= IDLE;
                    end else begin
                        cnt <= cnt - 4'd1;
                        if (cnt <= 4'd1) begin
                            state <= ACCESS;
                        end
                    end
                end
                ACCESS: begin
                    // MFA is not sampled here; the access always completes.
                    MFC <= 1'b1;
                    if (misalign) begin
                        DataOut <= '0;
                    end else if (!lat_rw) begin
                        DataOut <= rd_data;
                    end
                    state <= DONE;
                end
                DONE: begin
                    if (!MFA) begin
                        MFC   <= 1'b0;
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifdef RAM_ALIGN_CHECK_EN
    always_ff @(posedge CLK or posedge Reset) begin
        if (Reset) begin
            Fault <= 1'b0;
        end else if (state == ACCESS) begin
            Fault <= misalign;
        end else if (state == DONE && !MFA) begin
            Fault <= 1'b0;
        end
    end
`else
    assign Fault = 1'b0;
`endif

    // Storage array: big-endian, most-significant byte at the request address.
    always_ff @(posedge CLK) begin
        if (mem_we) begin
            case (lat_type)
                2'b00: begin
                    mem[lat_addr] <= lat_data[7:0];
                end
                2'b01: begin
                    mem[lat_addr] <= lat_data[15:8];
                    mem[a1]       <= lat_data[7:0];
                end
                default: begin
                    mem[lat_addr] <= lat_data[31:24];
                    mem[a1]       <= lat_data[23:16];
                    mem[a2]       <= lat_data[15:8];
                    mem[a3]       <= lat_data[7:0];
                end
            endcase
        end
    end

endmodule
